// File: rtl/div_sequencer_pkg.sv
// Shared encodings and constants for the signed iterative divider.
// Imported by div_sequencer and div_step.
package div_sequencer_pkg;

    localparam int DIV_STEPS = 32;

    // Encoding 3 is never entered; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_CALC  = 2'd1,
        DIV_FIXUP = 2'd2
    } div_state_t;

    // Sign flags latched at accept time and applied at fix-up.
    typedef struct packed {
        logic neg_q;
        logic neg_r;
    } div_sign_t;

endpackage

// File: rtl/div_sequencer_step.sv
// div_step: one restoring-division iteration on unsigned magnitudes.
// Latency: combinational. Backpressure: none, the caller sequences the steps.
// Usage: the partial remainder stays below divisor_mag between steps.
module div_step
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_STEPS
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           non_neg;

    // rem < divisor_mag, so rem's top bit is always 0; diff's top bit is a true borrow.
    assign shifted  = {rem, q[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor_mag};
    assign non_neg  = ~diff[WIDTH];
    assign rem_next = non_neg ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign q_next   = {q[WIDTH-2:0], non_neg};

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: signed DIV controller, restoring datapath and HI/LO registers.
// Latency: WIDTH+1 cycles from accept to HI/LO update; divide-by-zero writes on the accept edge.
// Backpressure: stall holds dependent MF reads and a re-presented start until IDLE.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_STEPS,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             mf_read,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] divisor_mag;
    div_sign_t        sign;

    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic             divisor_zero;
    logic             last_step;

    // Magnitude of the most negative value wraps to itself, which is correct unsigned.
    assign dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign divisor_zero = (divisor == '0);
    assign last_step    = (cnt == CNT_W'(WIDTH - 1));

    assign busy  = (state != DIV_IDLE);
    assign stall = busy & (mf_read | start);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem         (rem),
        .q           (q),
        .divisor_mag (divisor_mag),
        .rem_next    (rem_next),
        .q_next      (q_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: begin
                if (start && !divisor_zero) begin
                    state_nxt = DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (last_step) begin
                    state_nxt = DIV_FIXUP;
                end
            end
            DIV_FIXUP: begin
                state_nxt = DIV_IDLE;
            end
            default: begin
                state_nxt = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            rem         <= '0;
            q           <= '0;
            divisor_mag <= '0;
            sign        <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        if (divisor_zero) begin
                            // No trap: divide-by-zero resolves immediately to a defined pattern.
                            hi   <= dividend;
                            lo   <= '1;
                            done <= 1'b1;
                        end else begin
                            q           <= dividend_abs;
                            divisor_mag <= divisor_abs;
                            rem         <= '0;
                            cnt         <= '0;
                            sign.neg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            sign.neg_r  <= dividend[WIDTH-1];
                        end
                    end
                end
                DIV_CALC: begin
                    rem <= rem_next;
                    q   <= q_next;
                    cnt <= cnt + CNT_W'(1);
                end
                DIV_FIXUP: begin
                    lo   <= sign.neg_q ? -q   : q;
                    hi   <= sign.neg_r ? -rem : rem;
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: vector table, corner sequences and random pairs.
module tb_div_sequencer;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         mf_read;
    logic         busy;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         done;

    always #5 clk = ~clk;

    div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .mf_read  (mf_read),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo),
        .done     (done)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } vec_t;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } result_t;

    result_t sb[$];
    vec_t    vecs[12];
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint  sa;
        longint  sbv;
        longint  qq;
        longint  rr;
        result_t res;
        if (b == '0) begin
            res.lo = '1;
            res.hi = a;
        end else begin
            sa     = longint'($signed(a));
            sbv    = longint'($signed(b));
            qq     = sa / sbv;
            rr     = sa % sbv;
            res.lo = qq[W-1:0];
            res.hi = rr[W-1:0];
        end
        return res;
    endfunction

    // Called just after the accept edge; waits for done, then scores the result.
    task automatic wait_done(input string name, input int max_cyc, output int cyc, output int busy_cyc);
        result_t exp;
        cyc      = 0;
        busy_cyc = 0;
        while (!done && cyc < max_cyc) begin
            if (busy) busy_cyc++;
            tick();
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, cyc);
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: done with empty queue", name);
        end else begin
            exp = sb.pop_front();
            check({name, "_lo"}, lo, exp.lo);
            check({name, "_hi"}, hi, exp.hi);
        end
    endtask

    task automatic do_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
        int      cyc;
        int      bcyc;
        result_t r;
        r.lo     = exp_lo;
        r.hi     = exp_hi;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(r);
        tick();
        start = 1'b0;
        wait_done(name, LAT + 8, cyc, bcyc);
        check({name, "_latency"}, cyc, (b == '0) ? 0 : LAT);
        check({name, "_busy_cycles"}, bcyc, (b == '0) ? 0 : LAT);
        tick();
        check({name, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int      cyc;
        int      bcyc;
        logic    ok;
        result_t r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0]  = '{a: 32'd100,        b: 32'd7,          lo: 32'd14,         hi: 32'd2};
        vecs[1]  = '{a: -32'sd7,        b: 32'd2,          lo: 32'hFFFFFFFD,   hi: 32'hFFFFFFFF};
        vecs[2]  = '{a: 32'd7,          b: -32'sd2,        lo: 32'hFFFFFFFD,   hi: 32'd1};
        vecs[3]  = '{a: -32'sd7,        b: -32'sd2,        lo: 32'd3,          hi: 32'hFFFFFFFF};
        vecs[4]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   lo: 32'h80000000,   hi: 32'd0};
        vecs[5]  = '{a: 32'd5,          b: 32'd0,          lo: 32'hFFFFFFFF,   hi: 32'd5};
        vecs[6]  = '{a: 32'd0,          b: 32'd5,          lo: 32'd0,          hi: 32'd0};
        vecs[7]  = '{a: 32'hFFFFFFFF,   b: 32'h7FFFFFFF,   lo: 32'd0,          hi: 32'hFFFFFFFF};
        vecs[8]  = '{a: 32'h7FFFFFFF,   b: 32'h80000000,   lo: 32'd0,          hi: 32'h7FFFFFFF};
        vecs[9]  = '{a: 32'h80000000,   b: 32'h80000000,   lo: 32'd1,          hi: 32'd0};
        vecs[10] = '{a: 32'h7FFFFFFF,   b: 32'd1,          lo: 32'h7FFFFFFF,   hi: 32'd0};
        vecs[11] = '{a: 32'd20,         b: 32'd3,          lo: 32'd6,          hi: 32'd2};

        reset    = 1'b1;
        start    = 1'b0;
        mf_read  = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_stall", stall, 1'b0);
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        check("reset_done", done, 1'b0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
        end

        // Reset mid-divide: operands discarded, registers cleared immediately.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2 reset = 1'b1;
        #1;
        check("midreset_busy", busy, 1'b0);
        check("midreset_hi", hi, '0);
        check("midreset_lo", lo, '0);
        check("midreset_done", done, 1'b0);
        #2 reset = 1'b0;
        tick();
        do_div("after_reset", 32'd100, 32'd7, 32'd14, 32'd2);

        // MF read held from cycle 3 of a divide.
        dividend = 32'd20;
        divisor  = 32'd3;
        start    = 1'b1;
        r.lo = 32'd6;
        r.hi = 32'd2;
        sb.push_back(r);
        tick();
        start = 1'b0;
        cyc = 0;
        ok  = 1'b1;
        while (!done && cyc < LAT + 8) begin
            if (cyc == 2) mf_read = 1'b1;
            if (cyc >= 3 && !stall) ok = 1'b0;
            if (cyc == 10) begin
                check("hazard_hold_lo", lo, 32'd14);
                check("hazard_hold_hi", hi, 32'd2);
            end
            tick();
            cyc++;
        end
        check("hazard_stall_held", ok, 1'b1);
        check("hazard_latency", cyc, LAT);
        check("hazard_stall_release", stall, 1'b0);
        wait_done("hazard", 1, cyc, bcyc);
        mf_read = 1'b0;
        tick();
        mf_read = 1'b1;
        #1;
        check("idle_mf_stall", stall, 1'b0);
        mf_read = 1'b0;

        // Back-to-back: start held through the first divide.
        dividend = 32'd20;
        divisor  = 32'd3;
        start    = 1'b1;
        r.lo = 32'd6;
        r.hi = 32'd2;
        sb.push_back(r);
        tick();
        dividend = 32'd9;
        divisor  = 32'd4;
        r.lo = 32'd2;
        r.hi = 32'd1;
        sb.push_back(r);
        cyc = 0;
        ok  = 1'b1;
        while (!done && cyc < LAT + 8) begin
            if (!stall) ok = 1'b0;
            tick();
            cyc++;
        end
        check("b2b_stall_held", ok, 1'b1);
        check("b2b_first_latency", cyc, LAT);
        check("b2b_stall_idle", stall, 1'b0);
        wait_done("b2b_first", 1, cyc, bcyc);
        tick();
        start = 1'b0;
        check("b2b_second_accepted", busy, 1'b1);
        wait_done("b2b_second", LAT + 8, cyc, bcyc);
        check("b2b_second_latency", cyc, LAT);

        // Random signed pairs against a 64-bit reference.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            if (i % 3 == 0) rb = 32'($urandom_range(0, 30)) - 32'd15;
            else            rb = $urandom >> $urandom_range(0, 31);
            if (i % 5 == 0) rb = -rb;
            if (rb == '0) rb = 32'd1;
            r = model(ra, rb);
            do_div($sformatf("rand%0d", i), ra, rb, r.lo, r.hi);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
